countdown_core: RTL and testbench
=================================

COUNTDOWN_CORE -- requirements
Module: countdown_core

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, meaning tick_src rising edges per one-second decrement (legal range 1..65535).
REQ-002 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_src  input  1  divided-clock level from the upstream clock divider, synchronous to clk_in.
REQ-005 SHALL have port preset  input  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
REQ-006 SHALL have ports load, start, pause  input  1 each  single-cycle command pulses.
REQ-007 SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  current remaining time in BCD.
REQ-008 SHALL have ports running, paused, expired  output  1 each  state flags.
REQ-009 SHALL have ports done_pulse and load_err  output  1 each  single-cycle event flags.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, PAUSED, DONE; running=RUN, paused=PAUSED, expired=DONE, all registered.
REQ-011 SHALL detect tick edge as tick_src=1 and registered previous tick_src=0; one edge per low-to-high transition.
REQ-012 SHALL count tick edges in a prescaler only in RUN; prescaler frozen in PAUSED, cleared in IDLE/DONE and on load.
REQ-013 SHALL, on a tick edge with prescaler=TICKS_PER_SEC-1 in RUN, clear the prescaler and decrement the time by one second; new digits visible the cycle after the edge cycle.
REQ-014 SHALL decrement in BCD with borrow: sec_ones 0->9 borrow; sec_tens 0->5 borrow; min_ones 0->9 borrow; min_tens decrements.
REQ-015 SHALL, when the decrement produces 00:00, enter DONE in the same clock edge and assert done_pulse for exactly one cycle.
REQ-016 SHALL accept load only in IDLE, PAUSED or DONE; load in RUN ignored.
REQ-017 SHALL treat preset as invalid if any digit >9 or sec_tens >5; invalid load leaves digits/state unchanged and asserts load_err one cycle.
REQ-018 SHALL, on valid load, copy preset into digits and a stored-preset register and go to IDLE next cycle.
REQ-019 SHALL, on start in IDLE or PAUSED with nonzero digits, enter RUN; start with digits 00:00 ignored.
REQ-020 SHALL, on start in DONE, reload digits from stored preset and enter RUN (ignored if stored preset is 00:00).
REQ-021 SHALL, on pause in RUN, enter PAUSED; a decrement due in that same cycle is suppressed.
REQ-022 SHALL give priority load > pause > start when asserted together; start in RUN and pause outside RUN ignored.
REQ-023 SHALL keep digits and prescaler unchanged across PAUSED; resume continues from the frozen prescaler count.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state IDLE, digits 0, stored preset 0, prescaler 0, previous tick_src 0, all flags 0.
REQ-025 SHALL let rst override all commands and any in-flight decrement, from any state.

Structure
REQ-026 SHALL place state encoding constants, BCD digit limits (9, 5) and TICKS_PER_SEC default in shared package countdown_pkg.
REQ-027 SHALL use one sub-module, sec_prescaler: edge detect plus prescaler, outputs one-cycle sec_tick; enable/clear driven by the FSM.
REQ-028 SHALL keep BCD borrow logic and FSM in countdown_core.

Verification (TICKS_PER_SEC=2)
REQ-029 SHALL test: load 0x0103, start, 6 tick_src edges -> digits 01:03->01:02->01:01->01:00 after edges 2,4,6.
REQ-030 SHALL test: load 0x1000, start, 2 edges -> 09:59; load 0x0001, start, 2 edges -> 00:00, done_pulse one cycle, expired=1.
REQ-031 SHALL test: running 00:05, 1 edge, pause, 4 edges, start, 1 edge -> 00:04 exactly after resume edge.
REQ-032 SHALL test: load 0x0060 -> load_err one cycle, digits unchanged; load in RUN -> ignored; load+pause+start same cycle in PAUSED -> IDLE with new preset.
REQ-033 SHALL test: DONE then start -> digits restored to stored preset, RUN; rst asserted mid-RUN -> all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer.
//   state_e      : FSM state encoding (IDLE, RUN, PAUSED, DONE)
//   bcd_time_t   : {min_tens, min_ones, sec_tens, sec_ones}, one BCD digit each
//   preset_valid : true when every digit is <= 9 and sec_tens is <= 5
//   bcd_decrement: subtract one second with BCD borrow (caller guarantees non-zero)
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0]  BCD_ONES_MAX          = 4'd9;
    localparam logic [3:0]  BCD_TENS_MAX          = 4'd5;
    localparam int unsigned TICKS_PER_SEC_DEFAULT = 1000;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    function automatic logic preset_valid(input bcd_time_t t);
        return (t.min_tens <= BCD_ONES_MAX) && (t.min_ones <= BCD_ONES_MAX) &&
               (t.sec_tens <= BCD_TENS_MAX) && (t.sec_ones <= BCD_ONES_MAX);
    endfunction

    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_ones != 4'd0) begin
            r.sec_ones = t.sec_ones - 4'd1;
        end else begin
            r.sec_ones = BCD_ONES_MAX;
            if (t.sec_tens != 4'd0) begin
                r.sec_tens = t.sec_tens - 4'd1;
            end else begin
                r.sec_tens = BCD_TENS_MAX;
                if (t.min_ones != 4'd0) begin
                    r.min_ones = t.min_ones - 4'd1;
                end else begin
                    r.min_ones = BCD_ONES_MAX;
                    r.min_tens = t.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_core_sec_prescaler.sv
// Rising-edge detector on the divided tick level plus a prescaler that
// emits a one-cycle sec_tick_o every TICKS_PER_SEC counted edges.
//   clk_i, rst_i : clock / synchronous active-high reset
//   tick_src_i   : divided-clock level, synchronous to clk_i
//   enable_i     : count edges only while set (held off while paused)
//   clear_i      : force the count back to zero
//   sec_tick_o   : combinational, high in the cycle of the wrapping edge
module sec_prescaler
    import countdown_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_src_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic sec_tick_o
);

    localparam logic [15:0] LAST = 16'(TICKS_PER_SEC - 1);

    logic        prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic        tick_edge;

    assign tick_edge  = tick_src_i & ~prev_q;
    assign sec_tick_o = enable_i & ~clear_i & tick_edge & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && tick_edge) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= tick_src_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_core.sv
// MM:SS countdown timer in BCD with load/start/pause commands.
//   clk_in, rst          : clock / synchronous active-high reset
//   tick_src             : divided-clock level; TICKS_PER_SEC rising edges = 1 s
//   preset               : BCD {min_tens, min_ones, sec_tens, sec_ones}
//   load, start, pause   : single-cycle commands, priority load > pause > start
//   min_tens..sec_ones   : remaining time
//   running/paused/expired : registered state flags
//   done_pulse, load_err : one-cycle event flags
module countdown_core
    import countdown_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick_src,
    input  logic [15:0] preset,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        running,
    output logic        paused,
    output logic        expired,
    output logic        done_pulse,
    output logic        load_err
);

    state_e    state_q, state_d;
    bcd_time_t time_q, time_d;
    bcd_time_t stored_q, stored_d;
    bcd_time_t preset_t;
    logic      done_q, done_d;
    logic      err_q, err_d;
    logic      running_q, paused_q, expired_q;
    logic      load_ok, pre_en, pre_clr, sec_tick;

    assign preset_t = preset;
    // Load is ignored in RUN, so only a non-RUN valid load restarts the prescaler.
    assign load_ok  = load && (state_q != ST_RUN) && preset_valid(preset_t);
    // A pause arriving with a due edge swallows that edge entirely.
    assign pre_en   = (state_q == ST_RUN) && !pause;
    assign pre_clr  = (state_q == ST_IDLE) || (state_q == ST_DONE) || load_ok;

    sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
        .clk_i      (clk_in),
        .rst_i      (rst),
        .tick_src_i (tick_src),
        .enable_i   (pre_en),
        .clear_i    (pre_clr),
        .sec_tick_o (sec_tick)
    );

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        stored_d = stored_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (sec_tick) begin
                    time_d = bcd_decrement(time_q);
                    if (time_d == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_IDLE, ST_PAUSED, ST_DONE: begin
                if (load) begin
                    if (load_ok) begin
                        time_d   = preset_t;
                        stored_d = preset_t;
                        state_d  = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start) begin
                    if (state_q == ST_DONE) begin
                        if (stored_q != '0) begin
                            time_d  = stored_q;
                            state_d = ST_RUN;
                        end
                    end else if (time_q != '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            stored_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            stored_q  <= stored_d;
            done_q    <= done_d;
            err_q     <= err_d;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSED);
            expired_q <= (state_d == ST_DONE);
        end
    end

    assign min_tens   = time_q.min_tens;
    assign min_ones   = time_q.min_ones;
    assign sec_tens   = time_q.sec_tens;
    assign sec_ones   = time_q.sec_ones;
    assign running    = running_q;
    assign paused     = paused_q;
    assign expired    = expired_q;
    assign done_pulse = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_countdown_core.sv
module tb_countdown_core;

    localparam int TPS = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic        clk_in = 1'b0;
    logic        rst, tick_src, load, start, pause;
    logic [15:0] preset;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        running, paused, expired, done_pulse, load_err;

    always #5 clk_in = ~clk_in;

    countdown_core #(.TICKS_PER_SEC(TPS)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_src   (tick_src),
        .preset     (preset),
        .load       (load),
        .start      (start),
        .pause      (pause),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .paused     (paused),
        .expired    (expired),
        .done_pulse (done_pulse),
        .load_err   (load_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: remaining time kept as a plain count of seconds.
    int m_state, m_secs, m_stored, m_cnt;
    bit m_prev, m_done, m_err;

    function automatic int bcd_to_secs(input logic [15:0] p);
        return int'(p[15:12]) * 600 + int'(p[11:8]) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic bit preset_ok(input logic [15:0] p);
        return p[15:12] <= 9 && p[11:8] <= 9 && p[7:4] <= 5 && p[3:0] <= 9;
    endfunction

    // {digits, running, paused, expired, done_pulse, load_err}
    function automatic logic [20:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, running, paused, expired, done_pulse, load_err};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {secs_to_bcd(m_secs), m_state == M_RUN, m_state == M_PAUSED, m_state == M_DONE, m_done, m_err};
    endfunction

    task automatic model_step(input bit r, l, s, p, t, input logic [15:0] pr);
        bit edge_seen;
        if (r) begin
            m_state = M_IDLE; m_secs = 0; m_stored = 0; m_cnt = 0;
            m_prev = 0; m_done = 0; m_err = 0;
            return;
        end
        edge_seen = t && !m_prev;
        m_prev = t;
        m_done = 0;
        m_err  = 0;
        if (m_state == M_RUN) begin
            if (p) m_state = M_PAUSED;
            else if (edge_seen) begin
                m_cnt++;
                if (m_cnt == TPS) begin
                    m_cnt = 0;
                    m_secs--;
                    if (m_secs == 0) begin m_state = M_DONE; m_done = 1; end
                end
            end
        end else if (l) begin
            if (preset_ok(pr)) begin
                m_secs = bcd_to_secs(pr); m_stored = m_secs; m_cnt = 0; m_state = M_IDLE;
            end else m_err = 1;
        end else if (s) begin
            if (m_state == M_DONE) begin
                if (m_stored > 0) begin m_secs = m_stored; m_cnt = 0; m_state = M_RUN; end
            end else if (m_secs > 0) m_state = M_RUN;
        end
    endtask

    task automatic cycle(input bit r, l, s, p, t, input logic [15:0] pr);
        rst = r; load = l; start = s; pause = p; tick_src = t; preset = pr;
        model_step(r, l, s, p, t, pr);
        @(posedge clk_in);
        #1;
    endtask

    task automatic tick_edge();
        cycle(0, 0, 0, 0, 1, 16'h0);
        cycle(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 16'h0);
        cycle(1, 1, 1, 0, 1, 16'h0123);
        checks++;
        if (dut_vec() !== 21'h0) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", dut_vec(), 21'h0);
        end
    endtask

    task automatic test_count();
        logic [15:0] exp_d;
        cycle(0, 1, 0, 0, 0, 16'h0103);
        checks++;
        if (dut_vec() !== {16'h0103, 5'b00000}) begin
            failures++; $display("FAIL count_load got=%h exp=%h", dut_vec(), {16'h0103, 5'b00000});
        end
        cycle(0, 0, 1, 0, 0, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0103, 5'b10000}) begin
            failures++; $display("FAIL count_start got=%h exp=%h", dut_vec(), {16'h0103, 5'b10000});
        end
        for (int e = 1; e <= 6; e++) begin
            tick_edge();
            exp_d = 16'h0103 - 16'(e / 2);
            checks++;
            if (dut_vec() !== {exp_d, 5'b10000}) begin
                failures++; $display("FAIL count_edge%0d got=%h exp=%h", e, dut_vec(), {exp_d, 5'b10000});
            end
        end
    endtask

    task automatic test_borrow_done();
        cycle(0, 0, 0, 1, 0, 16'h0);
        cycle(0, 1, 0, 0, 0, 16'h1000);
        cycle(0, 0, 1, 0, 0, 16'h0);
        tick_edge(); tick_edge();
        checks++;
        if (dut_vec() !== {16'h0959, 5'b10000}) begin
            failures++; $display("FAIL borrow got=%h exp=%h", dut_vec(), {16'h0959, 5'b10000});
        end
        cycle(0, 0, 0, 1, 0, 16'h0);
        cycle(0, 1, 0, 0, 0, 16'h0001);
        cycle(0, 0, 1, 0, 0, 16'h0);
        tick_edge();
        cycle(0, 0, 0, 0, 1, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0000, 5'b00110}) begin
            failures++; $display("FAIL done_edge got=%h exp=%h", dut_vec(), {16'h0000, 5'b00110});
        end
        cycle(0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0000, 5'b00100}) begin
            failures++; $display("FAIL done_pulse_width got=%h exp=%h", dut_vec(), {16'h0000, 5'b00100});
        end
    endtask

    task automatic test_pause_resume();
        cycle(0, 1, 0, 0, 0, 16'h0005);
        cycle(0, 0, 1, 0, 0, 16'h0);
        tick_edge();
        cycle(0, 0, 0, 1, 0, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0005, 5'b01000}) begin
            failures++; $display("FAIL pause_enter got=%h exp=%h", dut_vec(), {16'h0005, 5'b01000});
        end
        for (int i = 0; i < 4; i++) tick_edge();
        checks++;
        if (dut_vec() !== {16'h0005, 5'b01000}) begin
            failures++; $display("FAIL pause_frozen got=%h exp=%h", dut_vec(), {16'h0005, 5'b01000});
        end
        cycle(0, 0, 1, 0, 0, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0005, 5'b10000}) begin
            failures++; $display("FAIL resume got=%h exp=%h", dut_vec(), {16'h0005, 5'b10000});
        end
        cycle(0, 0, 0, 0, 1, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0004, 5'b10000}) begin
            failures++; $display("FAIL resume_edge got=%h exp=%h", dut_vec(), {16'h0004, 5'b10000});
        end
        cycle(0, 0, 0, 1, 0, 16'h0);
    endtask

    task automatic test_load_rules();
        cycle(0, 1, 0, 0, 0, 16'h0200);
        cycle(0, 1, 0, 0, 0, 16'h0060);
        checks++;
        if (dut_vec() !== {16'h0200, 5'b00001}) begin
            failures++; $display("FAIL load_err got=%h exp=%h", dut_vec(), {16'h0200, 5'b00001});
        end
        cycle(0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0200, 5'b00000}) begin
            failures++; $display("FAIL load_err_width got=%h exp=%h", dut_vec(), {16'h0200, 5'b00000});
        end
        cycle(0, 0, 1, 0, 0, 16'h0);
        cycle(0, 1, 0, 0, 0, 16'h0300);
        checks++;
        if (dut_vec() !== {16'h0200, 5'b10000}) begin
            failures++; $display("FAIL load_in_run got=%h exp=%h", dut_vec(), {16'h0200, 5'b10000});
        end
        cycle(0, 0, 0, 1, 0, 16'h0);
        cycle(0, 1, 1, 1, 0, 16'h0045);
        checks++;
        if (dut_vec() !== {16'h0045, 5'b00000}) begin
            failures++; $display("FAIL load_priority got=%h exp=%h", dut_vec(), {16'h0045, 5'b00000});
        end
    endtask

    task automatic test_restart_and_rst();
        cycle(0, 1, 0, 0, 0, 16'h0001);
        cycle(0, 0, 1, 0, 0, 16'h0);
        tick_edge(); tick_edge();
        checks++;
        if (dut_vec() !== {16'h0000, 5'b00100}) begin
            failures++; $display("FAIL restart_done got=%h exp=%h", dut_vec(), {16'h0000, 5'b00100});
        end
        cycle(0, 0, 1, 0, 0, 16'h0);
        checks++;
        if (dut_vec() !== {16'h0001, 5'b10000}) begin
            failures++; $display("FAIL restart_reload got=%h exp=%h", dut_vec(), {16'h0001, 5'b10000});
        end
        tick_edge();
        cycle(1, 1, 1, 0, 1, 16'h0222);
        checks++;
        if (dut_vec() !== 21'h0) begin
            failures++; $display("FAIL rst_mid_run got=%h exp=%h", dut_vec(), 21'h0);
        end
        cycle(0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (dut_vec() !== 21'h0) begin
            failures++; $display("FAIL rst_idle_after got=%h exp=%h", dut_vec(), 21'h0);
        end
    endtask

    task automatic test_random();
        bit r, l, s, p, t;
        logic [15:0] pr;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            l = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 6);
            p = ($urandom_range(0, 99) < 3);
            t = tick_src ^ 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) pr = 16'($urandom);
            else pr = {4'd0, 4'($urandom_range(0, 1) & $urandom_range(0, 1)),
                       4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            cycle(r, l, s, p, t, pr);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick_src = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset = 16'h0;
        test_reset();
        test_count();
        test_borrow_done();
        test_pause_resume();
        test_load_rules();
        test_restart_and_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
